// File: rtl/alu_seq_unit.sv
// ALU with op/func decode, one-cycle logic ops and an iterative shift-add multiply behind valid/ready.
// Optional signed add/sub overflow detection is enabled by defining ALU_OVF_DETECT_EN.
module alu_seq_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       func_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_MUL, K_ILL} kind_t;

  state_t           state_q;
  kind_t            kind;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             lt;
  logic [WIDTH-1:0] result_q, ma_q, mb_q, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_q, illegal_q, out_valid_q;

  always_comb begin
    kind = K_ILL;
    case (alu_op)
      3'b000: kind = K_ADD;
      3'b001: kind = K_SUB;
      3'b100: kind = K_AND;
      3'b101: kind = K_OR;
      3'b110: kind = K_SLT;
      3'b111: begin
        case (func_code)
          6'b000010: kind = K_ADD;
          6'b000011: kind = K_SUB;
          6'b000100: kind = K_AND;
          6'b000101: kind = K_OR;
          6'b000111: kind = K_SLT;
          6'b000110: kind = MUL_EN ? K_MUL : K_ILL;
          default:   kind = K_ILL;
        endcase
      end
      default: kind = K_ILL;
    endcase
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign lt   = $signed(op_a) < $signed(op_b);

  // Illegal (and mul, which is not taken from here) yield zero so the zero flag follows naturally.
  always_comb begin
    alu_res = '0;
    case (kind)
      K_ADD:   alu_res = sum;
      K_SUB:   alu_res = diff;
      K_AND:   alu_res = op_a & op_b;
      K_OR:    alu_res = op_a | op_b;
      K_SLT:   alu_res = {{(WIDTH-1){1'b0}}, lt};
      default: alu_res = '0;
    endcase
  end

  assign acc_d = acc_q + (mb_q[0] ? ma_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (kind == K_MUL) begin
              ma_q    <= op_a;
              mb_q    <= op_b;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_EXEC;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              illegal_q   <= (kind == K_ILL);
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          acc_q <= acc_d;
          ma_q  <= ma_q << 1;
          mb_q  <= mb_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_q    <= acc_d;
            zero_q      <= (acc_d == '0);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_OVF_DETECT_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = 1'b0;
    if (kind == K_ADD)
      ovf_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    else if (kind == K_SUB)
      ovf_d = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
  end

  // Mul and illegal ops latch ovf_d = 0 at acceptance, so no update is needed in EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (state_q == S_IDLE && in_valid)
      ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
